ram_lsu: RTL

RAM_LSU -- requirements
Module: ram_lsu

---
 rtl/ram_lsu.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ram_lsu.sv
// ram_lsu: load/store unit between a core request port and a single-port synchronous-read RAM (byte/half via RMW).
// Latency: error 1 cycle, word store 2, load 3, byte/half store 4; one request in flight at a time.
// Backpressure: req_ready high only in IDLE; define LSU_RANGE_CHECK_EN to flag addresses beyond 4*DEPTH bytes.
module ram_lsu #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [AW-1:0]     address,
  output logic              wren,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lo_q, lo_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [AW-1:0]     address_q, address_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              mis_align;
  logic              out_of_range;
  logic              req_err;
  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted, lane_mask, load_ext, merged;

  // Alignment check on the live request: half needs addr[0]=0, word needs addr[1:0]=0, size 11 is never legal.
  always_comb begin
    mis_align = 1'b0;
    case (req_size)
      2'b00:   mis_align = 1'b0;
      2'b01:   mis_align = req_addr[0];
      2'b10:   mis_align = |req_addr[1:0];
      default: mis_align = 1'b1;
    endcase
  end

`ifdef LSU_RANGE_CHECK_EN
  assign out_of_range = (req_addr >> (AW + 2)) != 32'd0;
`else
  // Upper address bits are dropped so accesses wrap modulo 4*DEPTH bytes.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> (AW + 2));
  assign out_of_range   = 1'b0;
`endif

  assign req_err = mis_align | out_of_range;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: errors go straight to RESP, word stores skip the read, everything else reads first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                          state_d = RESP;
          else if (req_we && req_size == 2'b10) state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD:      state_d = DATA;
      DATA:    state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; gated by reset_n so an abort never leaks a write or response.
  always_comb begin
    req_ready = reset_n && (state_q == IDLE);
    wren      = reset_n && (state_q == WR);
    rsp_valid = reset_n && (state_q == RESP);
  end

  // Lane steering: extract/extend the addressed lane for loads and merge wdata into it for stores.
  always_comb begin
    sh      = {lo_q, 3'b000};
    shifted = data_out >> sh;
    case (size_q)
      2'b00: begin
        lane_mask = 32'h0000_00FF << sh;
        load_ext  = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_mask = 32'h0000_FFFF << sh;
        load_ext  = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        load_ext  = data_out;
      end
    endcase
    merged = (data_out & ~lane_mask) | ((wdata_q << sh) & lane_mask);
  end

  // Datapath next values: capture the request on accept, then fold in the RAM word during DATA.
  always_comb begin
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == IDLE && req_valid) begin
      we_d        = req_we;
      size_d      = req_size;
      uns_d       = req_unsigned;
      lo_d        = req_addr[1:0];
      wdata_d     = req_wdata;
      rsp_rdata_d = '0;
      rsp_err_d   = req_err;
      // A rejected request leaves the RAM-facing registers untouched.
      if (!req_err) begin
        address_d = req_addr[AW+1:2];
        data_in_d = req_wdata;
      end
    end else if (state_q == DATA) begin
      if (we_q) data_in_d   = merged;
      else      rsp_rdata_d = load_ext;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lo_q        <= 2'b00;
      wdata_q     <= '0;
      address_q   <= '0;
      data_in_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign address   = address_q;
  assign data_in   = data_in_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
